// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam int UART_DATA_OFS   = 0;
    localparam int UART_STATUS_OFS = 4;

    localparam int ST_NEMPTY      = 0;
    localparam int ST_FULL        = 1;
    localparam int ST_FERR        = 2;
    localparam int ST_OVR         = 3;
    localparam int DATA_VALID_BIT = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a combinational head output.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_rd;
    logic             do_wr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    // A pop frees the head slot in the same edge, so a write is accepted when full.
    assign do_rd = pop & ~empty;
    assign do_wr = push & (~full | do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PTR_ONE;
            if (do_rd) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a receive FIFO behind a two-register read-only bus window.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        uart_ren,
    input  logic [31:0] addr,
    output logic [31:0] uart_out,
    output logic        rx_irq
);

    localparam int DIV     = CLK_FREQ / BAUD;
    localparam int BCNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int SEL_BIT = $clog2(UART_STATUS_OFS - UART_DATA_OFS);

    localparam logic [BCNT_W-1:0] BCNT_HALF = BCNT_W'(DIV / 2 - 1);
    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);

    logic              rx_meta;
    logic              rxs;

    rx_state_t         state, state_d;
    logic [BCNT_W-1:0] bcnt, bcnt_d;
    logic [2:0]        bit_idx, bit_idx_d;
    logic [7:0]        sreg, sreg_d;
    logic              bcnt_zero;
    logic              push;
    logic              ferr_set;

    logic              ren_q;
    logic              rd_first;
    logic              sel_status;
    logic              pop;
    logic              st_clr;
    logic              ovr_set;
    logic              overrun;
    logic              frame_err;

    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    logic [31:0]       status_word;
    logic [31:0]       data_word;
    logic [31:0]       live_word;
    logic [31:0]       rd_hold;
    logic              unused_addr;

    assign unused_addr = ^{addr[31:SEL_BIT+1], addr[SEL_BIT-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            bcnt    <= '0;
            bit_idx <= '0;
            sreg    <= '0;
        end else begin
            state   <= state_d;
            bcnt    <= bcnt_d;
            bit_idx <= bit_idx_d;
            sreg    <= sreg_d;
        end
    end

    assign bcnt_zero = (bcnt == '0);

    always_comb begin
        state_d   = state;
        bcnt_d    = bcnt;
        bit_idx_d = bit_idx;
        sreg_d    = sreg;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rxs) begin
                    bcnt_d  = BCNT_HALF;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line at mid start bit; a high level here was a glitch.
                if (bcnt_zero) begin
                    if (!rxs) begin
                        bcnt_d    = BCNT_FULL;
                        bit_idx_d = '0;
                        state_d   = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    bcnt_d = bcnt - BCNT_ONE;
                end
            end
            RX_DATA: begin
                if (bcnt_zero) begin
                    sreg_d    = {rxs, sreg[7:1]};
                    bcnt_d    = BCNT_FULL;
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = RX_STOP;
                end else begin
                    bcnt_d = bcnt - BCNT_ONE;
                end
            end
            RX_STOP: begin
                if (bcnt_zero) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = RX_BREAK;
                    end
                end else begin
                    bcnt_d = bcnt - BCNT_ONE;
                end
            end
            RX_BREAK: begin
                if (rxs) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (sreg),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Only the first cycle of a (possibly stalled) bus read has side effects.
    assign rd_first   = uart_ren & ~ren_q;
    assign sel_status = addr[SEL_BIT];
    assign pop        = rd_first & ~sel_status;
    assign st_clr     = rd_first & sel_status;
    assign ovr_set    = push & fifo_full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ren_q     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rd_hold   <= '0;
        end else begin
            ren_q <= uart_ren;
            if (ovr_set)       overrun <= 1'b1;
            else if (st_clr)   overrun <= 1'b0;
            if (ferr_set)      frame_err <= 1'b1;
            else if (st_clr)   frame_err <= 1'b0;
            if (rd_first)      rd_hold <= live_word;
        end
    end

    always_comb begin
        status_word            = '0;
        status_word[ST_NEMPTY] = ~fifo_empty;
        status_word[ST_FULL]   = fifo_full;
        status_word[ST_FERR]   = frame_err;
        status_word[ST_OVR]    = overrun;
    end

    always_comb begin
        data_word = '0;
        if (!fifo_empty) begin
            data_word[DATA_VALID_BIT] = 1'b1;
            data_word[7:0]            = fifo_head;
        end
    end

    assign live_word = sel_status ? status_word : data_word;

    // Stall cycles keep returning the word the bus saw on the first read cycle.
    always_comb begin
        uart_out = '0;
        if (uart_ren) uart_out = ren_q ? rd_hold : live_word;
    end

    assign rx_irq = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue-based reference model checked every cycle.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 27000000;
    localparam int BAUD     = 115200;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 16;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        rx       = 1'b1;
    logic        uart_ren = 1'b0;
    logic [31:0] addr     = '0;
    logic [31:0] uart_out;
    logic        rx_irq;

    int checks = 0;
    int errors = 0;

    byte unsigned mq[$];
    bit           m_ovr      = 1'b0;
    bit           m_ferr     = 1'b0;
    bit           m_prev_ren = 1'b0;
    logic [31:0]  m_hold     = '0;
    bit           quiet      = 1'b0;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .uart_ren (uart_ren),
        .addr     (addr),
        .uart_out (uart_out),
        .rx_irq   (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_word(input bit st);
        logic [31:0] w;
        if (st)
            w = {28'b0, m_ovr, m_ferr, (mq.size() == DEPTH), (mq.size() != 0)};
        else if (mq.size() != 0)
            w = {23'b0, 1'b1, mq[0]};
        else
            w = 32'h0;
        return w;
    endfunction

    // Reference model: reads see a stable word for the whole stall, side effects on the first cycle.
    always @(negedge clk) begin
        logic [31:0] exp_out;
        logic        exp_irq;
        bit          st;
        if (!rst_n) begin
            mq.delete();
            m_ovr      = 1'b0;
            m_ferr     = 1'b0;
            m_prev_ren = 1'b0;
            chk("rst_out", uart_out, 32'h0);
            chk("rst_irq", {31'b0, rx_irq}, 32'h0);
        end else begin
            st      = addr[2];
            exp_irq = (mq.size() != 0);
            exp_out = 32'h0;
            if (uart_ren) begin
                if (!m_prev_ren) begin
                    exp_out = m_word(st);
                    m_hold  = exp_out;
                    if (st) begin
                        m_ovr  = 1'b0;
                        m_ferr = 1'b0;
                    end else if (mq.size() != 0) begin
                        void'(mq.pop_front());
                    end
                end else begin
                    exp_out = m_hold;
                end
            end
            chk("model_out", uart_out, exp_out);
            if (quiet) chk("model_irq", {31'b0, rx_irq}, {31'b0, exp_irq});
            m_prev_ren = uart_ren;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        quiet = 1'b0;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        if (stop_ok) begin
            rx = 1'b1;
            tick(DIV);
            if (mq.size() == DEPTH) m_ovr = 1'b1;
            else mq.push_back(b);
        end else begin
            rx = 1'b0;
            tick(3 * DIV);
            rx = 1'b1;
            tick(DIV);
            m_ferr = 1'b1;
        end
        tick(8);
        quiet = 1'b1;
    endtask

    task automatic rd(input string nm, input bit st, input logic [31:0] exp, input int n);
        uart_ren = 1'b1;
        addr     = st ? 32'h4000_1004 : 32'h4000_1000;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(nm, uart_out, exp);
            @(posedge clk);
            #1;
        end
        uart_ren = 1'b0;
        addr     = 32'h0;
        tick(1);
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pb;
        #2 rst_n = 1'b0;
        tick(3);
        chk("reset_out", uart_out, 32'h0);
        chk("reset_irq", {31'b0, rx_irq}, 32'h0);
        rst_n = 1'b1;
        tick(2);
        quiet = 1'b1;
        rd("reset_status", 1'b1, 32'h0, 1);

        // Single byte, then empty data and clean status.
        send_frame(8'hA5, 1'b1);
        chk("a5_irq", {31'b0, rx_irq}, 32'h1);
        rd("a5_data", 1'b0, 32'h0000_01A5, 1);
        rd("a5_empty", 1'b0, 32'h0, 1);
        rd("a5_status", 1'b1, 32'h0, 1);

        // Seventeen bytes into a sixteen-deep FIFO.
        for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1);
        rd("ovr_status", 1'b1, 32'hB, 1);
        for (int i = 0; i < 16; i++) rd("ovr_data", 1'b0, 32'h100 + i, 1);
        rd("ovr_empty", 1'b0, 32'h0, 1);
        rd("ovr_status2", 1'b1, 32'h0, 1);

        // Stalled read pops once and holds its word.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rd("stall_data", 1'b0, 32'h111, 4);
        rd("stall_next", 1'b0, 32'h122, 1);
        rd("stall_empty", 1'b0, 32'h0, 1);

        // Bad stop bit followed by a held-low line.
        send_frame(8'h3C, 1'b0);
        chk("ferr_irq", {31'b0, rx_irq}, 32'h0);
        rd("ferr_status", 1'b1, 32'h4, 1);
        send_frame(8'h55, 1'b1);
        rd("ferr_recover", 1'b0, 32'h155, 1);
        rd("ferr_status2", 1'b1, 32'h0, 1);

        // Short low glitch on the line.
        quiet = 1'b0;
        rx = 1'b0;
        tick(50);
        rx = 1'b1;
        tick(2 * DIV);
        quiet = 1'b1;
        chk("glitch_irq", {31'b0, rx_irq}, 32'h0);
        rd("glitch_status", 1'b1, 32'h0, 1);

        // Reset in the middle of data bit 4 with two bytes buffered.
        send_frame(8'h61, 1'b1);
        send_frame(8'h62, 1'b1);
        rd("prerst_status", 1'b1, 32'h1, 1);
        quiet = 1'b0;
        pb = 8'h7E;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = pb[i];
            tick(DIV);
        end
        rx = pb[4];
        tick(DIV / 2);
        rst_n = 1'b0;
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2 * DIV);
        quiet = 1'b1;
        chk("midrst_irq", {31'b0, rx_irq}, 32'h0);
        rd("midrst_status", 1'b1, 32'h0, 1);
        send_frame(8'h7E, 1'b1);
        rd("midrst_data", 1'b0, 32'h17E, 1);
        rd("midrst_empty", 1'b0, 32'h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
